// File: rtl/imem_loader_pkg.sv
// Shared types for the IRAM loader: FSM states, default frame marker, byte-lane index.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IRAM write port of the loader, bundled as one interface.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_wren;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_din;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_wren, imem_addr, imem_din
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_wren, imem_addr, imem_din
  );

endinterface

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog: expired is asserted during the TIMEOUT_CYCLES-th consecutive enabled cycle without a kick.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic clear,
  input  logic kick,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!clear || kick || !enable) begin
      count <= '0;
    end else if (count != W'(TIMEOUT_CYCLES)) begin
      count <= count + W'(1);
    end
  end

  // count holds the idle cycles already elapsed, so the current idle cycle is number count+1
  assign expired = enable && !kick && (count >= W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/imem_loader.sv
// Sole IRAM writer: parses A5/count/data/checksum frames from the UART and holds the core until a good frame lands.
module imem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                clock,
  input  logic                clear,
  imem_loader_if.master       bus,
  output logic                core_clear,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam int                CNT_W      = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_FRAME = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  expired;
  logic                  in_frame;
  lane_t                 byte_idx;
  logic [23:0]           asm_lo;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_W-1:0]      remaining;
  logic [7:0]            checksum;

  assign accept   = bus.rx_valid && bus.rx_ready;
  assign in_frame = (state == COUNT) || (state == DATA) || (state == CHECK);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .clear  (clear),
    .kick   (accept),
    .enable (in_frame),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && bus.rx_data == SYNC_BYTE) state_nxt = COUNT;
      COUNT: begin
        if (expired)     state_nxt = ERROR;
        else if (accept) state_nxt = DATA;
      end
      DATA: begin
        if (expired) state_nxt = ERROR;
        else if (accept && byte_idx == 2'd3 && remaining == CNT_W'(1)) state_nxt = CHECK;
      end
      CHECK: begin
        if (expired)     state_nxt = ERROR;
        else if (accept) state_nxt = (bus.rx_data == checksum) ? DONE : ERROR;
      end
      DONE:    state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready = 1'b1;
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

  // Frame datapath; the write pulse is registered so it lands the cycle after byte 3
  always_ff @(posedge clock) begin
    if (!clear) begin
      bus.imem_wren <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_din  <= '0;
      core_clear    <= 1'b1;
      error         <= 1'b0;
      words_loaded  <= '0;
      checksum      <= '0;
      byte_idx      <= '0;
      wr_ptr        <= '0;
      remaining     <= '0;
    end else begin
      bus.imem_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && bus.rx_data == SYNC_BYTE) begin
            core_clear   <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        COUNT: begin
          if (accept) begin
            remaining <= (bus.rx_data == 8'd0) ? FULL_FRAME : CNT_W'(bus.rx_data);
            byte_idx  <= '0;
            wr_ptr    <= '0;
            checksum  <= '0;
          end
        end
        DATA: begin
          if (accept && !expired) begin
            checksum <= checksum ^ bus.rx_data;
            byte_idx <= byte_idx + lane_t'(1);
            case (byte_idx)
              2'd0:    asm_lo[7:0]   <= bus.rx_data;
              2'd1:    asm_lo[15:8]  <= bus.rx_data;
              2'd2:    asm_lo[23:16] <= bus.rx_data;
              default: begin
                bus.imem_wren <= 1'b1;
                bus.imem_addr <= wr_ptr;
                bus.imem_din  <= {bus.rx_data, asm_lo};
                wr_ptr        <= wr_ptr + 1'b1;
                words_loaded  <= words_loaded + 1'b1;
                remaining     <= remaining - CNT_W'(1);
              end
            endcase
          end
        end
        DONE:    core_clear <= 1'b1;
        default: ;
      endcase
      if (state_nxt == ERROR) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IRAM writes are queued as frames are driven and matched on each write pulse.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int TO = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } wr_t;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          core_clear;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .bus         (bus),
    .core_clear  (core_clear),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int            checks   = 0;
  int            errors   = 0;
  int            wr_cnt   = 0;
  int            done_cnt = 0;
  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [7:0]    ck;
  logic [AW-1:0] exp_ptr;

  // Write/done monitor samples shortly after each rising edge
  always begin
    @(posedge clock);
    #2;
    if (bus.imem_wren === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h din %h, required no write", bus.imem_addr, bus.imem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.imem_addr !== mon_e.addr || bus.imem_din !== mon_e.din) begin
          errors++;
          $display("FAIL write_data: got addr %0h din %h, required addr %0h din %h",
                   bus.imem_addr, bus.imem_din, mon_e.addr, mon_e.din);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] n);
    send_byte(8'hA5, 0);
    send_byte(n, 0);
    ck      = 8'h00;
    exp_ptr = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    exp_q.push_back('{exp_ptr, w});
    exp_ptr++;
    for (int k = 0; k < 4; k++) begin
      ck ^= w[8*k +: 8];
      send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
    end
  endtask

  task automatic test_reset();
    clear        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    checks++; if (bus.imem_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b, required 0", bus.imem_wren); end
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h, required 00", bus.imem_addr); end
    checks++; if (bus.imem_din !== 32'h0) begin errors++; $display("FAIL rst_din: got %h, required 0", bus.imem_din); end
    checks++; if (core_clear !== 1'b1) begin errors++; $display("FAIL rst_core_clear: got %b, required 1", core_clear); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_done_error: got %b%b, required 00", done, error); end
    checks++; if (words_loaded !== 9'd0) begin errors++; $display("FAIL rst_words: got %0d, required 0", words_loaded); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready: got %b, required 1", bus.rx_ready); end
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_word();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    send_byte(8'hA5, 0);
    checks++; if (core_clear !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL s1_hold: got core_clear %b busy %b, required 0 1", core_clear, busy); end
    send_byte(8'h01, 0);
    ck = 8'h00; exp_ptr = '0;
    send_word(32'h00000113, 0);
    send_byte(8'h12, 0);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL s1_done: got done %b error %b, required 1 0", done, error); end
    checks++; if (core_clear !== 1'b0) begin errors++; $display("FAIL s1_clear_in_done: got %b, required 0", core_clear); end
    @(negedge clock);
    checks++; if (done !== 1'b0 || core_clear !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL s1_release: got done %b core_clear %b busy %b, required 0 1 0", done, core_clear, busy); end
    checks++; if (words_loaded !== 9'd1) begin errors++; $display("FAIL s1_words: got %0d, required 1", words_loaded); end
    checks++; if (wr_cnt !== w0 + 1 || done_cnt !== d0 + 1) begin errors++; $display("FAIL s1_counts: got writes %0d dones %0d, required %0d %0d", wr_cnt - w0, done_cnt - d0, 1, 1); end
  endtask

  task automatic test_gapped();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    start_frame(8'h02);
    send_word(32'h00000113, 5);
    send_word(32'h00000193, 5);
    send_byte(8'h80, $urandom_range(0, 5));
    @(negedge clock);
    checks++; if (words_loaded !== 9'd2) begin errors++; $display("FAIL s2_words: got %0d, required 2", words_loaded); end
    checks++; if (wr_cnt !== w0 + 2 || done_cnt !== d0 + 1) begin errors++; $display("FAIL s2_counts: got writes %0d dones %0d, required 2 1", wr_cnt - w0, done_cnt - d0); end
    checks++; if (error !== 1'b0 || core_clear !== 1'b1) begin errors++; $display("FAIL s2_status: got error %b core_clear %b, required 0 1", error, core_clear); end
  endtask

  task automatic test_bad_checksum();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    start_frame(8'h01);
    send_word(32'h00000113, 0);
    send_byte(8'h13, 0);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL s3_error: got error %b done %b, required 1 0", error, done); end
    repeat (3) @(negedge clock);
    checks++; if (error !== 1'b1 || core_clear !== 1'b0) begin errors++; $display("FAIL s3_sticky: got error %b core_clear %b, required 1 0", error, core_clear); end
    checks++; if (wr_cnt !== w0 + 1 || done_cnt !== d0) begin errors++; $display("FAIL s3_counts: got writes %0d dones %0d, required 1 0", wr_cnt - w0, done_cnt - d0); end
    send_byte(8'hA5, 0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL s3_error_clear: got %b, required 0", error); end
    send_byte(8'h01, 0);
    ck = 8'h00; exp_ptr = '0;
    send_word(32'hDEADBEEF, 2);
    send_byte(ck, 0);
    @(negedge clock);
    checks++; if (done_cnt !== d0 + 1 || core_clear !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL s3_recover: got dones %0d core_clear %b error %b, required 1 1 0", done_cnt - d0, core_clear, error); end
  endtask

  task automatic test_timeout();
    int w0 = wr_cnt;
    start_frame(8'h02);
    send_byte(8'h00, 0);
    repeat (TO - 1) @(negedge clock);
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL s4_early: got error %b busy %b, required 0 1", error, busy); end
    @(negedge clock);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL s4_expire: got %b, required 1", error); end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || core_clear !== 1'b0) begin errors++; $display("FAIL s4_after: got busy %b core_clear %b, required 0 0", busy, core_clear); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL s4_no_write: got %0d writes, required 0", wr_cnt - w0); end
  endtask

  task automatic test_full_frame();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    start_frame(8'h00);
    for (int i = 0; i < 256; i++) send_word($urandom, 0);
    send_byte(ck, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL s5_done: got %b, required 1", done); end
    @(negedge clock);
    checks++; if (words_loaded !== 9'd256) begin errors++; $display("FAIL s5_words: got %0d, required 256", words_loaded); end
    checks++; if (wr_cnt !== w0 + 256 || done_cnt !== d0 + 1) begin errors++; $display("FAIL s5_counts: got writes %0d dones %0d, required 256 1", wr_cnt - w0, done_cnt - d0); end
    checks++; if (bus.imem_addr !== 8'hFF || error !== 1'b0) begin errors++; $display("FAIL s5_last: got addr %h error %b, required ff 0", bus.imem_addr, error); end
  endtask

  task automatic test_clear_mid_frame();
    int d0;
    start_frame(8'h01);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    checks++; if (busy !== 1'b0 || bus.imem_wren !== 1'b0) begin errors++; $display("FAIL s6_idle: got busy %b wren %b, required 0 0", busy, bus.imem_wren); end
    checks++; if (core_clear !== 1'b1 || words_loaded !== 9'd0) begin errors++; $display("FAIL s6_reset: got core_clear %b words %0d, required 1 0", core_clear, words_loaded); end
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h01, 0);
    checks++; if (busy !== 1'b0 || core_clear !== 1'b1) begin errors++; $display("FAIL s6_garbage: got busy %b core_clear %b, required 0 1", busy, core_clear); end
    d0 = done_cnt;
    start_frame(8'h01);
    send_word(32'hCAFE0013, 1);
    send_byte(ck, 0);
    @(negedge clock);
    checks++; if (done_cnt !== d0 + 1 || words_loaded !== 9'd1) begin errors++; $display("FAIL s6_reload: got dones %0d words %0d, required 1 1", done_cnt - d0, words_loaded); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_gapped();
    test_bad_checksum();
    test_timeout();
    test_full_frame();
    test_clear_mid_frame();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-RAM port. The core only reads IRAM; this block is the one writer.
- Receives a framed byte stream from a UART receiver over valid/ready, assembles 32-bit little-endian words and writes them into IRAM (wren/ADDR/DIN) from address 0.
- Holds the core in clear while a frame is in flight, and releases it only after a frame passes its checksum.

Parameters:
ADDR_WIDTH, 8, IRAM word-address width; max frame length 2**ADDR_WIDTH words
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, idle cycles allowed between accepted bytes inside a frame

Ports:
clock  in  1  system clock; all logic on posedge
clear  in  1  synchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  byte accepted when rx_valid & rx_ready
imem_wren  out  1  IRAM write enable, one-cycle pulse per word
imem_addr  out  ADDR_WIDTH  IRAM word address
imem_din  out  32  IRAM write data
core_clear  out  1  active-low hold for the core; ANDed with the board clear at integration
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, frame loaded and checksum good
error  out  1  sticky; bad checksum or timeout
words_loaded  out  ADDR_WIDTH+1  words written in the current/last frame

Behaviour:
- Reset (clear=0 at posedge): state IDLE, imem_wren=0, imem_addr=0, imem_din=0, core_clear=1, done=0, error=0, words_loaded=0, checksum=0, timeout counter=0.
- rx_ready=1 in every state, so back-to-back bytes (one per cycle) are sustained.
- IDLE:
  - accepted byte == SYNC_BYTE -> COUNT; next cycle core_clear=0, error=0, words_loaded=0.
  - any other byte is discarded.
- COUNT:
  - the accepted byte is N, the word count. N=0 means 2**ADDR_WIDTH words.
  - load the remaining-word counter, clear byte_idx, write pointer and checksum; -> DATA.
- DATA:
  - accepted byte k (byte_idx 0..3) goes into assembly bits [8k+7:8k]; checksum ^= byte.
  - The cycle after byte 3 is accepted: imem_wren=1 for exactly one cycle, imem_addr=write pointer, imem_din=assembled word. Then the pointer increments (wraps mod 2**ADDR_WIDTH) and words_loaded increments.
  - After the last word's byte 3 -> CHECK.
  - SYNC_BYTE inside DATA is ordinary data; there is no resync.
- CHECK:
  - accepted byte == checksum -> DONE, else -> ERROR.
  - The checksum is the XOR of data bytes only, initial value 0.
- DONE: lasts one cycle; done=1; core_clear=1 from the next cycle; -> IDLE.
- ERROR: lasts one cycle; error=1 (sticky until the next SYNC_BYTE is accepted in IDLE); core_clear stays 0; -> IDLE.
- Timeout:
  - Applies in COUNT/DATA/CHECK. The counter increments each cycle with no accepted byte and clears on each accept.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - A partially assembled word is dropped, not written.
- Words written before an error stay in IRAM; there is no rollback. The core stays held until a later frame succeeds or clear is asserted.
- The final word's write pulse occurs in the first CHECK cycle. It does not conflict with the checksum byte acceptance.
- Reset mid-frame: same as reset values above. A partial write in flight is cancelled (imem_wren=0 in the reset cycle).
- Latency: from acceptance of byte 3 of a word to imem_wren is 1 cycle. From checksum byte acceptance to done is 1 cycle; core_clear rises 1 cycle after done.

Decomposition:
- Shared package loader_pkg:
  - state enum: IDLE, COUNT, DATA, CHECK, DONE, ERROR
  - SYNC_BYTE default
  - byte-lane index type
- One sub-module, loader_timeout: a parameterised idle-cycle counter with inputs kick/enable and output expired. Its width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. Bytes A5 01 13 01 00 00 12 back-to-back -> one imem_wren, addr 0, din 32'h00000113. done pulses 1 cycle after byte 12; error=0; core_clear low from the cycle after A5 until the cycle after done.
2. A5 02, then words 00000113 and 00000193 with random rx_valid gaps < TIMEOUT, then checksum 80 -> writes at addr 0 and 1; words_loaded=2; done=1.
3. Same as scenario 1 but checksum byte 13 -> error=1 sticky, done never pulses, addr 0 still written, core_clear stays 0. A following good frame clears error and pulses done.
4. A5 02 00, then rx_valid=0 -> error rises exactly TIMEOUT_CYCLES cycles after the 00 is accepted (test with TIMEOUT_CYCLES=16); no imem_wren.
5. A5 00 + 1024 data bytes + correct checksum -> 256 writes, last addr 8'hFF, words_loaded=256, pointer wraps to 0.
6. clear=0 for one cycle after the second data byte of a frame -> IDLE, imem_wren=0, core_clear=1. Garbage bytes are ignored; the next A5 frame writes from addr 0.
